fp32_mul_sequencer: RTL and testbench
=====================================

Name: fp32_mul_sequencer

Overview:
- Top-level controller for single-precision IEEE-754 multiply, built around the existing 24x24 shift-add mantissa multiplier.
- Accepts packed operands on a valid/ready handshake, unpacks and classifies them, and resolves special cases without using the multiplier.
- For normal operands: pulses the multiplier start, waits for its done strobe, normalizes, rounds to nearest-even and returns a packed result with flags on a second valid/ready handshake.

Parameters:
TIMEOUT, 64, maximum cycles spent in WAIT before aborting.
CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept operands.
in_a  input  32  operand A, IEEE-754 single.
in_b  input  32  operand B, IEEE-754 single.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_result  output  32  packed product.
out_flags  output  5  {timeout, invalid, overflow, underflow, inexact}.
mul_start  output  1  one-cycle start pulse to mantissa multiplier.
mul_x  output  24  mantissa A with hidden bit.
mul_y  output  24  mantissa B with hidden bit.
mul_p  input  48  multiplier product.
mul_done  input  1  multiplier result-valid strobe.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE. Outputs clear: in_ready=1, out_valid=0, mul_start=0, out_result=0, out_flags=0, mul_x=0, mul_y=0. Reset mid-operation abandons the operation; any later mul_done is ignored.
- IDLE: in_ready=1. On in_valid&in_ready, register the operands and go to CLASSIFY. in_ready=0 in all other states.
- CLASSIFY: exponent 0 is treated as zero; subnormals flush to signed zero. Priority order, all go directly to DONE:
  1. Either operand NaN, or inf*0: result 0x7FC00000, invalid=1.
  2. Either operand inf: result signed inf.
  3. Either operand zero: result signed zero.
  Otherwise load mul_x/mul_y = {1, frac} and go to START.
- Result sign is always sA^sB, except canonical NaN.
- START: mul_start=1 for exactly this cycle; clear counter; go to WAIT.
- WAIT: counter increments each cycle. If mul_done=1, capture mul_p and go to NORM. If counter reaches TIMEOUT first, result=0x7FC00000, timeout=1, go to DONE. mul_done outside WAIT is ignored.
- NORM: exponent e = eA+eB-127, 10-bit signed. If p[47]=1, mantissa = p[46:24], guard = p[23], sticky = |p[22:0], e+1. Else mantissa = p[45:23], guard = p[22], sticky = |p[21:0].
- ROUND: round to nearest-even (increment when guard & (sticky | lsb)). A mantissa carry-out adds 1 to e and zeroes the mantissa.
  - e>=255: signed inf, overflow=1, inexact=1.
  - e<=0: signed zero, underflow=1, inexact=1.
  - Otherwise inexact = guard|sticky.
  Go to DONE.
- DONE: out_valid=1. out_result and out_flags stay stable until out_valid&out_ready, then go to IDLE with out_valid=0 the next cycle. No new operand is accepted in the cycle the result is taken.
- Latency:
  - Special case: out_valid high 2 edges after the accept edge.
  - Normal: mul_start high in the cycle after CLASSIFY; out_valid high 3 edges after the edge that samples mul_done=1.

Decomposition:
- Shared package fp32_pkg: state enum {IDLE, CLASSIFY, START, WAIT, NORM, ROUND, DONE}; constants QNAN=32'h7FC00000, EXP_BIAS=127, EXP_MAX=255; flag bit indices.
- One natural sub-module: fp32_round_pack (combinational normalize, round and pack from product, exponent and sign). The FSM, operand registers and timeout counter stay in the top module.

Test Plan:
- Multiplier model returns x*y 25 cycles after mul_start. in_a=0x3FC00000, in_b=0x40000000 -> out_result=0x40400000, flags=0, exactly one mul_start pulse.
- 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1. Then 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow|inexact.
- 0x7F800001 * 0x3F800000 -> 0x7FC00000, invalid=1. 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1. 0x80000000 * 0x40000000 -> 0x80000000. In all three cases mul_start never asserts and out_valid rises 2 edges after accept.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result and flags stable, in_ready=0. Accepted on the cycle out_ready=1.
- Multiplier model never asserts mul_done -> after 64 WAIT cycles, out_result=0x7FC00000 with timeout=1. A late mul_done is ignored.
- Drive reset=0 for one edge while in WAIT -> IDLE, in_ready=1, all outputs zero. The old mul_done is ignored, and the next operation completes correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the single-precision multiply sequencer:
//   - FSM state encodings (3-bit constants, also exported on the debug port)
//   - IEEE-754 constants (canonical quiet NaN, exponent bias, max exponent)
//   - bit positions inside the 5-bit flag vector
//   - operand classification helper
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLASSIFY = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_NORM     = 3'd4;
    localparam logic [2:0] ST_ROUND    = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;

    // Flag vector layout: {timeout, invalid, overflow, underflow, inexact}
    localparam int FLG_TIMEOUT   = 4;
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Exponent 0 counts as zero: subnormals are flushed, never multiplied.
    function automatic fp_class_t fp_classify(input logic [31:0] v);
        fp_class_t c;
        c.nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        c.inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        c.zero = (v[30:23] == 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// -----------------------------------------------------------------------------
// fp32_round_pack
// Combinational normalize / round-to-nearest-even / pack of a 48-bit mantissa
// product into an IEEE-754 single.
// Ports:
//   i_prod   [47:0]  raw product of the two 24-bit mantissas (hidden bits set)
//   i_exp    [9:0]   signed biased exponent before normalization (eA+eB-127)
//   i_sign           result sign
//   o_result [31:0]  packed result (signed inf on overflow, signed zero on
//                    underflow)
//   o_flags  [4:0]   {timeout, invalid, overflow, underflow, inexact}; only
//                    overflow/underflow/inexact can be set here
// -----------------------------------------------------------------------------
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic        [47:0] i_prod,
    input  logic signed [9:0]  i_exp,
    input  logic               i_sign,
    output logic        [31:0] o_result,
    output logic        [4:0]  o_flags
);

    logic               w_hi;
    logic        [22:0] w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic        [23:0] w_mant_r;
    logic signed [9:0]  w_exp_n;
    logic signed [9:0]  w_exp_r;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4): bit 47 tells which.
        w_hi = i_prod[47];
        if (w_hi) begin
            w_mant   = i_prod[46:24];
            w_guard  = i_prod[23];
            w_sticky = |i_prod[22:0];
        end else begin
            w_mant   = i_prod[45:23];
            w_guard  = i_prod[22];
            w_sticky = |i_prod[21:0];
        end
        w_exp_n = i_exp + $signed({9'd0, w_hi});

        // Ties go to the even mantissa.
        w_inc    = w_guard & (w_sticky | w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {23'd0, w_inc};
        // A carry out of the rounded mantissa leaves its low 23 bits zero,
        // so only the exponent needs bumping.
        w_exp_r  = w_exp_n + $signed({9'd0, w_mant_r[23]});

        o_flags = '0;
        if (w_exp_r >= $signed(10'(EXP_MAX))) begin
            o_result               = {i_sign, 8'hFF, 23'd0};
            o_flags[FLG_OVERFLOW]  = 1'b1;
            o_flags[FLG_INEXACT]   = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            o_result               = {i_sign, 31'd0};
            o_flags[FLG_UNDERFLOW] = 1'b1;
            o_flags[FLG_INEXACT]   = 1'b1;
        end else begin
            o_result               = {i_sign, w_exp_r[7:0], w_mant_r[22:0]};
            o_flags[FLG_INEXACT]   = w_guard | w_sticky;
        end
    end

endmodule

// File: rtl/fp32_mul_sequencer.sv
// -----------------------------------------------------------------------------
// fp32_mul_sequencer
// Controller for IEEE-754 single-precision multiply around an external 24x24
// shift-add mantissa multiplier. Special operands are resolved locally; normal
// operands go through the multiplier, then normalize/round/pack.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised, the payload holds steady until that edge.
// in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), synchronous active-low reset
//   i_in_valid/o_in_ready   operand handshake; i_in_a, i_in_b operands
//   o_out_valid/i_out_ready result handshake; o_out_result, o_out_flags
//                           flags = {timeout, invalid, overflow, underflow,
//                           inexact}
//   o_mul_start             one-cycle start pulse to the mantissa multiplier
//   o_mul_x, o_mul_y        mantissas with hidden bit
//   i_mul_p, i_mul_done     multiplier product and its valid strobe
//   o_dbg_state             current FSM state (fp32_pkg ST_* encoding)
// -----------------------------------------------------------------------------
module fp32_mul_sequencer
    import fp32_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_a,
    input  logic [31:0] i_in_b,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_result,
    output logic [4:0]  o_out_flags,
    output logic        o_mul_start,
    output logic [23:0] o_mul_x,
    output logic [23:0] o_mul_y,
    input  logic [47:0] i_mul_p,
    input  logic        i_mul_done,
    output logic [2:0]  o_dbg_state
);

    logic        [2:0]       r_state;
    logic        [31:0]      r_a;
    logic        [31:0]      r_b;
    logic        [23:0]      r_mul_x;
    logic        [23:0]      r_mul_y;
    logic        [CNT_W-1:0] r_cnt;
    logic        [47:0]      r_prod;
    logic signed [9:0]       r_exp;
    logic        [31:0]      r_result;
    logic        [4:0]       r_flags;

    fp_class_t   w_cls_a;
    fp_class_t   w_cls_b;
    logic        w_sign;
    logic [31:0] w_rp_result;
    logic [4:0]  w_rp_flags;

    assign w_cls_a = fp_classify(r_a);
    assign w_cls_b = fp_classify(r_b);
    assign w_sign  = r_a[31] ^ r_b[31];

    fp32_round_pack u_round_pack (
        .i_prod   (r_prod),
        .i_exp    (r_exp),
        .i_sign   (w_sign),
        .o_result (w_rp_result),
        .o_flags  (w_rp_flags)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mul_x  <= '0;
            r_mul_y  <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_in_a;
                        r_b     <= i_in_b;
                        r_state <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    r_flags <= '0;
                    if (w_cls_a.nan || w_cls_b.nan ||
                        (w_cls_a.inf && w_cls_b.zero) ||
                        (w_cls_b.inf && w_cls_a.zero)) begin
                        r_result             <= QNAN;
                        r_flags[FLG_INVALID] <= 1'b1;
                        r_state              <= ST_DONE;
                    end else if (w_cls_a.inf || w_cls_b.inf) begin
                        r_result <= {w_sign, 8'hFF, 23'd0};
                        r_state  <= ST_DONE;
                    end else if (w_cls_a.zero || w_cls_b.zero) begin
                        r_result <= {w_sign, 31'd0};
                        r_state  <= ST_DONE;
                    end else begin
                        r_mul_x <= {1'b1, r_a[22:0]};
                        r_mul_y <= {1'b1, r_b[22:0]};
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done strobe in the last counted cycle still wins.
                    if (i_mul_done) begin
                        r_prod  <= i_mul_p;
                        r_state <= ST_NORM;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_result             <= QNAN;
                        r_flags              <= '0;
                        r_flags[FLG_TIMEOUT] <= 1'b1;
                        r_state              <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_NORM: begin
                    // 10-bit signed so both underflow (<=0) and overflow are visible.
                    r_exp   <= {2'b00, r_a[30:23]} + {2'b00, r_b[30:23]} - 10'(EXP_BIAS);
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_result <= w_rp_result;
                    r_flags  <= w_rp_flags;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready   = (r_state == ST_IDLE);
    assign o_out_valid  = (r_state == ST_DONE);
    assign o_mul_start  = (r_state == ST_START);
    assign o_mul_x      = r_mul_x;
    assign o_mul_y      = r_mul_y;
    assign o_out_result = r_result;
    assign o_out_flags  = r_flags;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp32_mul_sequencer
// Directed vectors with hand-computed IEEE-754 results against
// fp32_mul_sequencer, with a behavioural mantissa multiplier that answers
// x*y 25 cycles after each start pulse.
// -----------------------------------------------------------------------------
module tb_fp32_mul_sequencer;
    import fp32_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        mul_start;
    logic [23:0] mul_x;
    logic [23:0] mul_y;
    logic [47:0] mul_p     = '0;
    logic        mul_done;
    logic [2:0]  dbg_state;

    logic        mdl_done = 1'b0;
    logic        tb_done  = 1'b0;
    assign mul_done = mdl_done | tb_done;

    fp32_mul_sequencer #(.TIMEOUT(64), .CNT_W(7)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_a       (in_a),
        .i_in_b       (in_b),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_result (out_result),
        .o_out_flags  (out_flags),
        .o_mul_start  (mul_start),
        .o_mul_x      (mul_x),
        .o_mul_y      (mul_y),
        .i_mul_p      (mul_p),
        .i_mul_done   (mul_done),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- multiplier model ----------------
    // A new start restarts the countdown; mdl_en=0 models a hung multiplier.
    bit          mdl_en  = 1'b1;
    int          mdl_cnt = 0;
    logic [23:0] mdl_x   = '0;
    logic [23:0] mdl_y   = '0;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && mdl_en) begin
                mdl_done <= 1'b1;
                mul_p    <= {24'd0, mdl_x} * {24'd0, mdl_y};
            end
        end
        if (mul_start) begin
            mdl_x   <= mul_x;
            mdl_y   <= mul_y;
            mdl_cnt <= 25;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the negedge after the accept edge with in_valid dropped.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_at_send", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // exp_lat counts edges inclusively: from the accept edge (special cases)
    // or from the edge that samples mul_done (normal cases) up to and
    // including the edge that raises out_valid. 0 skips the latency check.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [4:0] exp_flg,
                          input int exp_lat, input int exp_starts, input int hold);
        logic [36:0] e;
        int          k;
        int          kd;
        int          starts;
        int          lat;
        bit          got;
        exp_q.push_back({exp_flg, exp_res});
        send(a, b);
        k = 0; kd = -1; starts = 0; got = 1'b0;
        while (!got && k < 300) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (mul_start) starts++;
            if (kd < 0 && mul_done) kd = k;
            if (out_valid) got = 1'b1;
        end
        chk("out_valid_seen", 32'(got), 32'd1);
        e = exp_q.pop_front();
        if (got) begin
            chk("result", out_result, e[31:0]);
            chk("flags", 32'(out_flags), 32'(e[36:32]));
            chk("mul_starts", 32'(starts), 32'(exp_starts));
            lat = (kd < 0) ? k + 1 : k - kd;
            if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_result", out_result, e[31:0]);
                chk("hold_flags", 32'(out_flags), 32'(e[36:32]));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk("out_valid_after_take", 32'(out_valid), 32'd0);
            chk("in_ready_after_take", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_flags"}, 32'(out_flags), 32'd0);
        chk({tag, "_mul_x"}, 32'(mul_x), 32'd0);
        chk({tag, "_mul_y"}, 32'(mul_y), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        bit stray;
        bit saw_done;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1.5 * 2.0 = 3.0, held 5 cycles in DONE
        run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 3, 1, 5);
        // (1+2^-23)^2: sticky only, no round-up
        run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 5'b00001, 3, 1, 0);
        // 1.5*(1+2^-23): exact tie, rounds to even mantissa ...02
        run_op(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 5'b00001, 3, 1, 0);
        // (2-2^-23)^2: product bit 47 set path
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 5'b00001, 3, 1, 0);
        // 2^127 * 2^127: overflow to +inf
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 5'b00101, 3, 1, 0);
        // 2^-126 * 2^-126: underflow to +0
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00011, 3, 1, 0);
        // special cases: no multiplier, 2-edge latency
        run_op(32'h7F80_0001, 32'h3F80_0000, QNAN,         5'b01000, 2, 0, 0);
        run_op(32'h7F80_0000, 32'h0000_0000, QNAN,         5'b01000, 2, 0, 0);
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 5'b00000, 2, 0, 0);
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 5'b00000, 2, 0, 0);

        // Hung multiplier: CLASSIFY, START, then 64 WAIT edges -> 67 inclusive.
        mdl_en = 1'b0;
        run_op(32'h3F80_0000, 32'h3F80_0000, QNAN, 5'b10000, 67, 1, 0);
        mdl_en = 1'b1;
        @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        chk("late_done_out_valid", 32'(out_valid), 32'd0);
        chk("late_done_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset while WAITing; the stale multiplier answer must be ignored.
        send(32'h3FC0_0000, 32'h4000_0000);
        repeat (5) @(negedge clk);
        chk("pre_reset_state", 32'(dbg_state), 32'(ST_WAIT));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("mid_reset");
        stray = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_done) saw_done = 1'b1;
            if (out_valid || dbg_state != ST_IDLE) stray = 1'b1;
        end
        chk("stale_done_seen", 32'(saw_done), 32'd1);
        chk("stale_done_ignored", 32'(stray), 32'd0);
        // 3.0 * 2.0 = 6.0
        run_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 5'b00000, 3, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
